debug_unit_ctrl: RTL

Command controller between the MicroBlaze control-frame link and the MIPS pipeline. It turns 32-bit frames from the MicroBlaze into pipeline sequencing: run/step/halt, pipeline reset, instruction-memory loading, and debug-data readout through a request/acknowledge handshake. It sits inside `pipeline`. It drives the global enable and reset of the five stages and the debug read port that selects latches, registers and memories.

---
 rtl/debug_unit_pkg.sv | 61 ++++++
 rtl/blaze_frame_sampler.sv | 37 +++
 rtl/debug_unit_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_unit_pkg.sv
// Shared constants for the MicroBlaze debug controller: frame layout, command codes,
// debug read selectors, FSM encoding and the status-word packer.
package debug_unit_pkg;

    localparam int unsigned NB_CONTROL_FRAME = 32;
    localparam int unsigned NB_CODE          = 6;
    localparam int unsigned NB_ADDR_TYPE     = 9;
    localparam int unsigned NB_ADDR_DATA     = 16;
    localparam int unsigned NB_INSTR_ADDR    = 9;
    localparam int unsigned NB_INSTR         = 32;

    localparam int unsigned FRAME_CODE_LSB   = 26;
    localparam int unsigned FRAME_VALID_BIT  = 25;
    localparam int unsigned FRAME_TYPE_LSB   = 16;
    localparam int unsigned FRAME_ADDR_LSB   = 0;

    localparam logic [NB_CODE-1:0] CMD_START          = 6'd1;
    localparam logic [NB_CODE-1:0] CMD_RESET          = 6'd2;
    localparam logic [NB_CODE-1:0] CMD_LOAD_INSTR_LSB = 6'd3;
    localparam logic [NB_CODE-1:0] CMD_LOAD_INSTR_MSB = 6'd4;
    localparam logic [NB_CODE-1:0] CMD_REQ_DATA       = 6'd5;
    localparam logic [NB_CODE-1:0] CMD_MODE_GET       = 6'd6;
    localparam logic [NB_CODE-1:0] CMD_MODE_SET_CONT  = 6'd7;
    localparam logic [NB_CODE-1:0] CMD_MODE_SET_STEP  = 6'd8;
    localparam logic [NB_CODE-1:0] CMD_STEP           = 6'd9;
    localparam logic [NB_CODE-1:0] CMD_GOT_DATA       = 6'd10;
    localparam logic [NB_CODE-1:0] CMD_GIB_DATA       = 6'd11;

    localparam logic [NB_ADDR_TYPE-1:0] REQ_MEM_DATA        = 9'd0;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_MEM_INSTR       = 9'd1;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_REGISTERS       = 9'd2;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_FETCH     = 9'd3;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_DECO_DATA = 9'd4;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_DECO_CTRL = 9'd5;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_EXEC_DATA = 9'd6;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_EXEC_CTRL = 9'd7;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_MEM_DATA  = 9'd8;
    localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_MEM_CTRL  = 9'd9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_ONE  = 3'd3,
        ST_XFER_RD   = 3'd4,
        ST_XFER_HOLD = 3'd5,
        ST_HALTED    = 3'd6
    } state_e;

    function automatic logic [NB_CONTROL_FRAME-1:0] pack_status(
        input logic [NB_CODE-1:0]      last_code,
        input logic                    mode,
        input state_e                  state,
        input logic                    error,
        input logic                    halted,
        input logic [NB_ADDR_DATA-1:0] load_count
    );
        return {last_code, mode, state, error, halted, 4'b0000, load_count};
    endfunction

endpackage

// File: rtl/blaze_frame_sampler.sv
// Splits the MicroBlaze control frame into fields and flags the first cycle of each new command.
module blaze_frame_sampler
    import debug_unit_pkg::*;
(
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    output logic                        o_fresh_c,
    output logic [NB_CODE-1:0]          o_code_c,
    output logic [NB_ADDR_TYPE-1:0]     o_addr_type_c,
    output logic [NB_ADDR_DATA-1:0]     o_address_c
);

    logic               prev_valid;
    logic [NB_CODE-1:0] prev_code;
    logic               valid_c;

    always_comb begin
        valid_c       = i_frame[FRAME_VALID_BIT];
        o_code_c      = i_frame[FRAME_CODE_LSB +: NB_CODE];
        o_addr_type_c = i_frame[FRAME_TYPE_LSB +: NB_ADDR_TYPE];
        o_address_c   = i_frame[FRAME_ADDR_LSB +: NB_ADDR_DATA];
        o_fresh_c     = valid_c && (!prev_valid || (o_code_c != prev_code));
    end

    // Previous-cycle view used to suppress the repeats of a held frame.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            prev_valid <= 1'b0;
            prev_code  <= '0;
        end else begin
            prev_valid <= valid_c;
            prev_code  <= o_code_c;
        end
    end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Command controller turning MicroBlaze frames into pipeline run/step/halt, reset,
// instruction loading and debug readout. Instruction loading exists only with DBG_INSTR_LOAD_EN.
module debug_unit_ctrl
    import debug_unit_pkg::*;
(
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
    output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
    output logic                        o_pipe_enable,
    output logic                        o_pipe_reset,
    output logic                        o_instr_we,
    output logic [NB_INSTR_ADDR-1:0]    o_instr_addr,
    output logic [NB_INSTR-1:0]         o_instr_data,
    output logic [NB_ADDR_TYPE-1:0]     o_dbg_type,
    output logic [NB_ADDR_DATA-1:0]     o_dbg_addr,
    input  logic [NB_INSTR-1:0]         i_dbg_data,
    input  logic                        i_halt
);

    logic                    fresh_c;
    logic [NB_CODE-1:0]      code_c;
    logic [NB_ADDR_TYPE-1:0] addr_type_c;
    logic [NB_ADDR_DATA-1:0] address_c;

    blaze_frame_sampler u_sampler (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_frame       (i_frame_from_blaze),
        .o_fresh_c     (fresh_c),
        .o_code_c      (code_c),
        .o_addr_type_c (addr_type_c),
        .o_address_c   (address_c)
    );

    state_e                      state, state_n, saved_state, saved_state_n;
    logic                        mode, mode_n, error, error_n, rd_wait, rd_wait_n;
    logic [NB_CODE-1:0]          last_code, last_code_n;
    logic [NB_ADDR_TYPE-1:0]     dbg_type_n;
    logic [NB_ADDR_DATA-1:0]     dbg_addr_n;
    logic [NB_CONTROL_FRAME-1:0] frame_n;
    logic                        pipe_enable_n, pipe_reset_n, capture;
    logic [NB_ADDR_DATA-1:0]     status_count;
`ifdef DBG_INSTR_LOAD_EN
    logic [NB_INSTR_ADDR-1:0]    load_count, load_count_n, instr_addr_n;
    logic                        load_pend, load_pend_n, instr_we_n;
    logic [NB_INSTR-1:0]         instr_data_n;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            saved_state      <= ST_IDLE;
            mode             <= 1'b0;
            error            <= 1'b0;
            rd_wait          <= 1'b0;
            last_code        <= '0;
            o_dbg_type       <= '0;
            o_dbg_addr       <= '0;
            o_frame_to_blaze <= '0;
            o_pipe_enable    <= 1'b0;
            o_pipe_reset     <= 1'b0;
`ifdef DBG_INSTR_LOAD_EN
            load_count       <= '0;
            load_pend        <= 1'b0;
            o_instr_we       <= 1'b0;
            o_instr_addr     <= '0;
            o_instr_data     <= '0;
`endif
        end else begin
            state            <= state_n;
            saved_state      <= saved_state_n;
            mode             <= mode_n;
            error            <= error_n;
            rd_wait          <= rd_wait_n;
            last_code        <= last_code_n;
            o_dbg_type       <= dbg_type_n;
            o_dbg_addr       <= dbg_addr_n;
            o_frame_to_blaze <= frame_n;
            o_pipe_enable    <= pipe_enable_n;
            o_pipe_reset     <= pipe_reset_n;
`ifdef DBG_INSTR_LOAD_EN
            load_count       <= load_count_n;
            load_pend        <= load_pend_n;
            o_instr_we       <= instr_we_n;
            o_instr_addr     <= instr_addr_n;
            o_instr_data     <= instr_data_n;
`endif
        end
    end

`ifndef DBG_INSTR_LOAD_EN
    assign o_instr_we   = 1'b0;
    assign o_instr_addr = '0;
    assign o_instr_data = '0;
`endif

    always_comb begin
        state_n       = state;
        saved_state_n = saved_state;
        mode_n        = mode;
        error_n       = error;
        rd_wait_n     = rd_wait;
        last_code_n   = fresh_c ? code_c : last_code;
        dbg_type_n    = o_dbg_type;
        dbg_addr_n    = o_dbg_addr;
        pipe_reset_n  = 1'b0;
        capture       = 1'b0;
`ifdef DBG_INSTR_LOAD_EN
        // An MSB frame arms load_pend; the write lands one cycle later.
        load_pend_n   = 1'b0;
        instr_we_n    = load_pend;
        instr_addr_n  = load_pend ? load_count : o_instr_addr;
        instr_data_n  = o_instr_data;
        load_count_n  = load_pend ? load_count + 9'd1 : load_count;
`endif

        if (fresh_c && (code_c == CMD_RESET)) begin
            state_n      = ST_IDLE;
            error_n      = 1'b0;
            rd_wait_n    = 1'b0;
            pipe_reset_n = 1'b1;
`ifdef DBG_INSTR_LOAD_EN
            load_count_n = '0;
            instr_we_n   = 1'b0;
`endif
        end else if (i_halt && ((state == ST_RUN) || (state == ST_STEP_ONE))) begin
            state_n = ST_HALTED;
        end else begin
            case (state)
                ST_STEP_ONE: state_n = ST_STEP_WAIT;
                ST_XFER_RD: begin
                    // Wait one cycle for the registered debug read to return.
                    if (rd_wait) begin
                        rd_wait_n = 1'b0;
                    end else begin
                        state_n = ST_XFER_HOLD;
                        capture = 1'b1;
                    end
                end
                default: ;
            endcase

            if (fresh_c) begin
                case (code_c)
                    CMD_START: begin
                        if (state == ST_IDLE) state_n = mode ? ST_STEP_WAIT : ST_RUN;
                    end
                    CMD_STEP: begin
                        if (state == ST_STEP_WAIT) state_n = ST_STEP_ONE;
                    end
                    CMD_MODE_SET_CONT: mode_n = 1'b0;
                    CMD_MODE_SET_STEP: mode_n = 1'b1;
                    CMD_MODE_GET: ;
                    CMD_REQ_DATA: begin
                        // A nested request keeps the state saved by the outer one.
                        if ((state != ST_XFER_RD) && (state != ST_XFER_HOLD))
                            saved_state_n = (state == ST_STEP_ONE) ? ST_STEP_WAIT : state;
                        dbg_type_n = addr_type_c;
                        dbg_addr_n = address_c;
                        state_n    = ST_XFER_RD;
                        rd_wait_n  = 1'b1;
                        capture    = 1'b0;
                    end
                    CMD_GIB_DATA: begin
                        if (state == ST_XFER_HOLD) begin
                            dbg_addr_n = o_dbg_addr + 16'd1;
                            state_n    = ST_XFER_RD;
                            rd_wait_n  = 1'b1;
                        end
                    end
                    CMD_GOT_DATA: begin
                        if (state == ST_XFER_HOLD) state_n = saved_state;
                    end
                    CMD_LOAD_INSTR_LSB: begin
`ifdef DBG_INSTR_LOAD_EN
                        if (state == ST_IDLE) instr_data_n[15:0] = address_c;
                        else                  error_n = 1'b1;
`else
                        error_n = 1'b1;
`endif
                    end
                    CMD_LOAD_INSTR_MSB: begin
`ifdef DBG_INSTR_LOAD_EN
                        if (state == ST_IDLE) begin
                            instr_data_n[31:16] = address_c;
                            load_pend_n         = 1'b1;
                        end else begin
                            error_n = 1'b1;
                        end
`else
                        error_n = 1'b1;
`endif
                    end
                    default: error_n = 1'b1;
                endcase
            end
        end

`ifdef DBG_INSTR_LOAD_EN
        status_count = 16'(load_count_n);
`else
        status_count = 16'd0;
`endif
        pipe_enable_n = (state_n == ST_RUN) || (state_n == ST_STEP_ONE);
        if (state_n == ST_XFER_HOLD)
            frame_n = capture ? i_dbg_data : o_frame_to_blaze;
        else
            frame_n = pack_status(last_code_n, mode_n, state_n, error_n,
                                  (state_n == ST_HALTED), status_count);
    end

endmodule
